// File: rtl/mdio_phy_slv_if.sv
// MDIO pin bundle between a MAC-side master and the PHY model,
// plus the observation outputs the PHY reports on register writes.
interface mdio_phy_slv_if;
  logic        mdc;
  logic        mdo;
  logic        mdoEn;
  logic        mdi;
  logic        busy;
  logic        wr_pulse;
  logic [4:0]  wr_regad;
  logic [15:0] wr_data;

  modport master (
    output mdc, mdo, mdoEn,
    input  mdi, busy, wr_pulse,
    input  wr_regad, wr_data
  );

  modport slave (
    input  mdc, mdo, mdoEn,
    output mdi, busy, wr_pulse,
    output wr_regad, wr_data
  );
endinterface

// File: rtl/mdio_phy_slv.sv
// Clause 22 MDIO PHY responder with a 32x16 register file.
// All protocol actions happen on synchronized rising edges of mdc.
module mdio_phy_slv #(
  parameter logic [4:0]  PHY_ADDR = 5'h01,
  parameter logic [15:0] PHY_ID1  = 16'h0022,
  parameter logic [15:0] PHY_ID2  = 16'h1620
) (
  input  logic            CLK,
  input  logic            RSTn,
  mdio_phy_slv_if.slave   mdio
);

  typedef enum logic [2:0] {
    IDLE,
    ST,
    OP,
    PHYAD,
    REGAD,
    TA,
    RDATA,
    WDATA
  } state_t;

  localparam logic [15:0] REG0_RST = 16'h1140;
  localparam logic [15:0] REG1_VAL = 16'h796D;
  localparam logic [31:0][15:0] RF_RST =
    {{31{16'h0000}}, REG0_RST};

  logic [1:0]  mdc_s;
  logic [1:0]  line_s;
  logic        mdc_q;
  logic        mdc_rise;
  logic        line;
  logic        smp;

  state_t      state;
  state_t      state_n;
  logic [4:0]  bcnt;
  logic [4:0]  bcnt_n;
  logic [5:0]  ones;
  logic [5:0]  ones_n;
  logic [1:0]  op;
  logic [1:0]  op_n;
  logic [4:0]  phyad;
  logic [4:0]  phyad_n;
  logic [4:0]  regad;
  logic [4:0]  regad_n;
  logic [15:0] sreg;
  logic [15:0] sreg_n;
  logic        mdi_q;
  logic        mdi_n;
  logic        wr_pulse_q;
  logic        wr_pulse_n;
  logic [4:0]  wr_regad_q;
  logic [4:0]  wr_regad_n;
  logic [15:0] wr_data_q;
  logic [15:0] wr_data_n;

  logic              rf_we;
  logic              soft_rst;
  logic [31:0][15:0] rf;
  logic [15:0]       rd_val;
  logic              match;
  logic              is_rd;
  logic              writable;

  assign line     = mdio.mdoEn ? mdio.mdo : 1'b1;
  assign mdc_rise = mdc_s[1] & ~mdc_q;
  assign smp      = line_s[1];
  assign match    = (phyad == PHY_ADDR);
  assign is_rd    = (op == 2'b10);
  assign writable = (regad != 5'd1) &&
                    (regad != 5'd2) &&
                    (regad != 5'd3);
  assign soft_rst = rf_we && (regad == 5'd0)
                    && sreg_n[15];

  assign mdio.mdi      = mdi_q;
  assign mdio.busy     = (state != IDLE);
  assign mdio.wr_pulse = wr_pulse_q;
  assign mdio.wr_regad = wr_regad_q;
  assign mdio.wr_data  = wr_data_q;

  // Bring mdc and the line into CLK, keep last mdc for edge detect.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mdc_s  <= 2'b00;
      line_s <= 2'b11;
      mdc_q  <= 1'b0;
    end else begin
      mdc_s  <= {mdc_s[0], mdio.mdc};
      line_s <= {line_s[0], line};
      mdc_q  <= mdc_s[1];
    end
  end

  // Read view: bit 15 of reg0 is self-clearing, regs 1-3 fixed.
  always_comb begin
    rd_val = rf[regad];
    unique case (regad)
      5'd0:    rd_val = {1'b0, rf[0][14:0]};
      5'd1:    rd_val = REG1_VAL;
      5'd2:    rd_val = PHY_ID1;
      5'd3:    rd_val = PHY_ID2;
      default: ;
    endcase
  end

  // Frame state register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and datapath updates, one step per mdc rise.
  always_comb begin
    state_n    = state;
    bcnt_n     = bcnt;
    ones_n     = ones;
    op_n       = op;
    phyad_n    = phyad;
    regad_n    = regad;
    sreg_n     = sreg;
    mdi_n      = mdi_q;
    wr_pulse_n = 1'b0;
    wr_regad_n = wr_regad_q;
    wr_data_n  = wr_data_q;
    rf_we      = 1'b0;
    if (mdc_rise) begin
      unique case (state)
        IDLE: begin
          if (smp) begin
            if (ones < 6'd32)
              ones_n = ones + 6'd1;
          end else if (ones >= 6'd32) begin
            state_n = ST;
            ones_n  = 6'd0;
            bcnt_n  = 5'd0;
          end else begin
            ones_n = 6'd0;
          end
        end
        ST: begin
          state_n = smp ? OP : IDLE;
          bcnt_n  = 5'd0;
        end
        OP: begin
          op_n   = {op[0], smp};
          bcnt_n = bcnt + 5'd1;
          if (bcnt == 5'd1) begin
            bcnt_n = 5'd0;
            if ({op[0], smp} == 2'b10 ||
                {op[0], smp} == 2'b01)
              state_n = PHYAD;
            else
              state_n = IDLE;
          end
        end
        PHYAD: begin
          phyad_n = {phyad[3:0], smp};
          bcnt_n  = bcnt + 5'd1;
          if (bcnt == 5'd4) begin
            bcnt_n  = 5'd0;
            state_n = REGAD;
          end
        end
        REGAD: begin
          regad_n = {regad[3:0], smp};
          bcnt_n  = bcnt + 5'd1;
          if (bcnt == 5'd4) begin
            bcnt_n  = 5'd0;
            state_n = TA;
          end
        end
        TA: begin
          if (is_rd) begin
            mdi_n   = ~match;
            sreg_n  = rd_val;
            bcnt_n  = 5'd0;
            state_n = RDATA;
          end else if (bcnt == 5'd0) begin
            if (smp) bcnt_n = 5'd1;
            else     state_n = IDLE;
          end else begin
            bcnt_n  = 5'd0;
            state_n = smp ? IDLE : WDATA;
          end
        end
        RDATA: begin
          if (bcnt == 5'd16) begin
            mdi_n   = 1'b1;
            bcnt_n  = 5'd0;
            state_n = IDLE;
          end else begin
            mdi_n  = match ? sreg[15] : 1'b1;
            sreg_n = {sreg[14:0], 1'b0};
            bcnt_n = bcnt + 5'd1;
          end
        end
        WDATA: begin
          sreg_n = {sreg[14:0], smp};
          bcnt_n = bcnt + 5'd1;
          if (bcnt == 5'd15) begin
            bcnt_n  = 5'd0;
            state_n = IDLE;
            if (match && writable) begin
              rf_we      = 1'b1;
              wr_pulse_n = 1'b1;
              wr_regad_n = regad;
              wr_data_n  = {sreg[14:0], smp};
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Frame datapath and write-report registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      bcnt       <= 5'd0;
      ones       <= 6'd0;
      op         <= 2'b00;
      phyad      <= 5'd0;
      regad      <= 5'd0;
      sreg       <= 16'h0000;
      mdi_q      <= 1'b1;
      wr_pulse_q <= 1'b0;
      wr_regad_q <= 5'd0;
      wr_data_q  <= 16'h0000;
    end else begin
      bcnt       <= bcnt_n;
      ones       <= ones_n;
      op         <= op_n;
      phyad      <= phyad_n;
      regad      <= regad_n;
      sreg       <= sreg_n;
      mdi_q      <= mdi_n;
      wr_pulse_q <= wr_pulse_n;
      wr_regad_q <= wr_regad_n;
      wr_data_q  <= wr_data_n;
    end
  end

  // Register file; a soft reset via reg0 bit 15 wins over the write.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      rf <= RF_RST;
    else if (soft_rst)
      rf <= RF_RST;
    else if (rf_we)
      rf[regad] <= sreg_n;
  end

endmodule

// File: tb/tb_mdio_phy_slv.sv
// Bench for mdio_phy_slv: MAC-side bit driver plus a
// register-level model of what each frame should do.
module tb_mdio_phy_slv;

  logic CLK = 1'b0;
  logic RSTn;

  mdio_phy_slv_if mdio();

  mdio_phy_slv #(
    .PHY_ADDR (5'h01),
    .PHY_ID1  (16'h0022),
    .PHY_ID2  (16'h1620)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .mdio (mdio.slave)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  logic [15:0] m_rf [32];

  always @(negedge CLK)
    if (mdio.wr_pulse === 1'b1) pulses++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 16'h0000;
    m_rf[0] = 16'h1140;
  endfunction

  function automatic logic [15:0] m_rd(input logic [4:0] ra);
    case (ra)
      5'd0:    return m_rf[0] & 16'h7FFF;
      5'd1:    return 16'h796D;
      5'd2:    return 16'h0022;
      5'd3:    return 16'h1620;
      default: return m_rf[ra];
    endcase
  endfunction

  task automatic bit_out(input logic b, input logic en,
                         output logic m);
    @(negedge CLK);
    mdio.mdc   = 1'b0;
    mdio.mdo   = b;
    mdio.mdoEn = en;
    repeat (4) @(negedge CLK);
    mdio.mdc = 1'b1;
    repeat (4) @(negedge CLK);
    m = mdio.mdi;
  endtask

  task automatic preamble(input int n);
    logic m;
    for (int i = 0; i < n; i++) bit_out(1'b1, 1'b1, m);
  endtask

  task automatic send_hdr(input logic [1:0] op,
                          input logic [4:0] phy,
                          input logic [4:0] ra);
    logic m;
    bit_out(1'b0, 1'b1, m);
    bit_out(1'b1, 1'b1, m);
    bit_out(op[1], 1'b1, m);
    bit_out(op[0], 1'b1, m);
    for (int i = 4; i >= 0; i--) bit_out(phy[i], 1'b1, m);
    for (int i = 4; i >= 0; i--) bit_out(ra[i], 1'b1, m);
  endtask

  task automatic do_read(input int pre,
                         input logic [4:0] phy,
                         input logic [4:0] ra,
                         input int rst_at);
    logic m;
    logic resp;
    logic [15:0] got;
    logic [15:0] exp;
    resp = (pre >= 32) && (phy == 5'd1);
    exp  = resp ? m_rd(ra) : 16'hFFFF;
    got  = 16'h0000;
    preamble(pre);
    send_hdr(2'b10, phy, ra);
    chk("rd_busy", {31'd0, mdio.busy}, {31'd0, pre >= 32});
    bit_out(1'b1, 1'b0, m);
    chk("rd_ta", {31'd0, m}, {31'd0, ~resp});
    for (int k = 15; k >= 0; k--) begin
      bit_out(1'b1, 1'b0, m);
      got[k] = m;
      if (k == rst_at) begin
        chk("rst_pre_mdi", {31'd0, m}, {31'd0, exp[k]});
        RSTn = 1'b0;
        #1;
        chk("rst_mdi", {31'd0, mdio.mdi}, 32'd1);
        chk("rst_busy", {31'd0, mdio.busy}, 32'd0);
        chk("rst_regad", {27'd0, mdio.wr_regad}, 32'd0);
        chk("rst_wdata", {16'd0, mdio.wr_data}, 32'd0);
        m_reset();
        mdio.mdc   = 1'b0;
        mdio.mdoEn = 1'b0;
        repeat (4) @(negedge CLK);
        RSTn = 1'b1;
        repeat (4) @(negedge CLK);
        return;
      end
    end
    chk("rd_data", {16'd0, got}, {16'd0, exp});
    bit_out(1'b1, 1'b0, m);
    chk("rd_rel", {31'd0, m}, 32'd1);
    chk("rd_idle", {31'd0, mdio.busy}, 32'd0);
  endtask

  task automatic do_write(input int pre,
                          input logic [4:0] phy,
                          input logic [4:0] ra,
                          input logic [15:0] d,
                          input logic [1:0] ta);
    logic m;
    int p0;
    logic ok;
    p0 = pulses;
    ok = (pre >= 32) && (ta == 2'b10) && (phy == 5'd1)
         && (ra != 5'd1) && (ra != 5'd2) && (ra != 5'd3);
    preamble(pre);
    send_hdr(2'b01, phy, ra);
    bit_out(ta[1], 1'b1, m);
    bit_out(ta[0], 1'b1, m);
    for (int i = 15; i >= 0; i--) bit_out(d[i], 1'b1, m);
    repeat (2) @(negedge CLK);
    chk("wr_cnt", pulses - p0, {31'd0, ok});
    chk("wr_idle", {31'd0, mdio.busy}, 32'd0);
    if (ok) begin
      chk("wr_regad", {27'd0, mdio.wr_regad}, {27'd0, ra});
      chk("wr_data", {16'd0, mdio.wr_data}, {16'd0, d});
      if (ra == 5'd0 && d[15]) m_reset();
      else m_rf[ra] = d;
    end
  endtask

  initial begin
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [15:0] d;
    int pre;
    m_reset();
    RSTn       = 1'b0;
    mdio.mdc   = 1'b0;
    mdio.mdo   = 1'b1;
    mdio.mdoEn = 1'b0;
    repeat (5) @(negedge CLK);
    chk("rst0_mdi", {31'd0, mdio.mdi}, 32'd1);
    chk("rst0_busy", {31'd0, mdio.busy}, 32'd0);
    chk("rst0_pulse", {31'd0, mdio.wr_pulse}, 32'd0);
    chk("rst0_regad", {27'd0, mdio.wr_regad}, 32'd0);
    chk("rst0_wdata", {16'd0, mdio.wr_data}, 32'd0);
    RSTn = 1'b1;
    repeat (4) @(negedge CLK);

    do_read(32, 5'd1, 5'd2, -1);
    do_read(32, 5'd1, 5'd3, -1);
    do_read(32, 5'd1, 5'd1, -1);
    do_read(32, 5'd1, 5'd0, -1);

    do_write(32, 5'd1, 5'd4, 16'hA5A5, 2'b10);
    do_read(32, 5'd1, 5'd4, -1);

    do_read(32, 5'd3, 5'd4, -1);
    do_write(32, 5'd3, 5'd4, 16'h5A5A, 2'b10);
    do_read(32, 5'd1, 5'd4, -1);

    do_read(31, 5'd1, 5'd2, -1);
    do_write(32, 5'd1, 5'd5, 16'hFFFF, 2'b11);
    do_write(32, 5'd1, 5'd5, 16'h0F0F, 2'b00);
    do_read(32, 5'd1, 5'd5, -1);

    do_write(32, 5'd1, 5'd4, 16'h1234, 2'b10);
    do_write(32, 5'd1, 5'd0, 16'h8000, 2'b10);
    do_read(32, 5'd1, 5'd4, -1);
    do_read(32, 5'd1, 5'd0, -1);
    do_write(32, 5'd1, 5'd2, 16'hBEEF, 2'b10);
    do_read(32, 5'd1, 5'd2, -1);

    do_write(32, 5'd1, 5'd0, 16'h0000, 2'b10);
    do_read(32, 5'd1, 5'd0, 7);
    do_read(32, 5'd1, 5'd0, -1);

    for (int it = 0; it < 40; it++) begin
      phy = ($urandom_range(0, 3) == 0) ?
            5'($urandom) : 5'd1;
      ra  = 5'($urandom);
      d   = 16'($urandom);
      pre = 32 + int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(pre, phy, ra, d, 2'b10);
      else
        do_read(pre, phy, ra, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
